state_register_bank: RTL and testbench
======================================

Name: state_register_bank

Overview:
- Parametrised successor to the fixed 5x64-bit ASCON state register.
- Holds NB_WORDS words of WORD_W bits and supports four update modes: hold, masked load, single-word XOR absorb, and masked full-state XOR.
- Provides a one-entry snapshot buffer with a valid/ready handshake, so the controller can export intermediate state (tag/ciphertext extraction) without stalling the permutation datapath.

Parameters:
- NB_WORDS, 5, number of state words.
- WORD_W, 64, bits per word.
- SEL_W, $clog2(NB_WORDS) (min 1), width of word select.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_i  in  1  synchronous, active-high reset.
- en_i  in  1  update enable; 0 = state holds regardless of mode_i.
- mode_i  in  2  00 HOLD, 01 LOAD, 10 XOR_WORD, 11 XOR_STATE.
- word_mask_i  in  NB_WORDS  per-word enable for LOAD / XOR_STATE.
- word_sel_i  in  SEL_W  target word for XOR_WORD.
- state_i  in  NB_WORDS*WORD_W  word k = bits [k*WORD_W +: WORD_W].
- data_i  in  WORD_W  operand for XOR_WORD.
- snap_req_i  in  1  request snapshot of current state.
- snap_ready_i  in  1  consumer accepts snapshot.
- state_o  out  NB_WORDS*WORD_W  registered state.
- snap_o  out  NB_WORDS*WORD_W  snapshot buffer.
- snap_valid_o  out  1  snapshot buffer holds unconsumed data.
- snap_ovf_o  out  1  sticky: request dropped because buffer full.
- upd_o  out  1  pulse: state changed value last cycle.
- sel_err_o  out  1  pulse: XOR_WORD with word_sel_i >= NB_WORDS.

Behaviour:
- Reset (reset_i=1 at a clock edge): state_o, snap_o, snap_valid_o, snap_ovf_o, upd_o and sel_err_o all go to 0. Reset has priority over every other input. Reset asserted mid-operation discards any pending snapshot and any in-flight update.
- Update (at a clock edge with en_i=1); all updates have 1-cycle latency, visible on state_o after the edge:
  - HOLD: no change.
  - LOAD: word k <= state_i word k where word_mask_i[k]=1; other words hold.
  - XOR_WORD: word[word_sel_i] <= word[word_sel_i] ^ data_i; other words hold. If word_sel_i >= NB_WORDS: no change, and sel_err_o=1 for one cycle.
  - XOR_STATE: word k <= word k ^ state_i word k where word_mask_i[k]=1.
- en_i=0: state holds, sel_err_o=0.
- upd_o: registered; 1 in the cycle after an edge where the new state differs from the old. A masked-off load or an XOR with zero gives upd_o=0.
- Snapshot buffer:
  - Accept condition: snap_req_i=1 and (snap_valid_o=0 or snap_ready_i=1).
  - On accept: snap_o <= state_o as it was before that edge (the pre-update value); snap_valid_o <= 1.
  - Consume: snap_ready_i=1 and snap_valid_o=1 with no accept gives snap_valid_o <= 0. snap_o holds its last value.
  - Simultaneous consume and request: the old entry is consumed, the new one is loaded, and snap_valid_o stays 1.
  - Overflow: snap_req_i=1, snap_valid_o=1, snap_ready_i=0. The request is dropped, snap_o is unchanged, and snap_ovf_o <= 1 (sticky until reset).
  - snap_ready_i with snap_valid_o=0 is ignored.
- Snapshot and state update are independent and may occur in the same cycle.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset/load: hold reset_i=1 for 2 cycles, then check state_o=0 and snap_valid_o=0. Apply en_i=1, mode=01, mask=5'b11111, all words 64'h0123456789ABCDEF. One cycle later all 5 words equal 0123456789ABCDEF and upd_o=1.
- Masked load / enable: mask=5'b00100 with state_i words = 64'hFFFF_FFFF_FFFF_FFFF. Only word 2 changes. Repeat with en_i=0: no change and upd_o=0.
- XOR_WORD: word0=64'h0123456789ABCDEF, data_i=64'hFFFFFFFF00000000 gives word0=64'hFEDCBA9889ABCDEF. With word_sel_i=5 (SEL_W=3): state unchanged and sel_err_o pulses 1.
- Snapshot handshake: snap_req with snap_ready_i=0 gives snap_valid_o=1 and snap_o equal to the pre-update state. A second request while still full drops, leaving snap_o unchanged and snap_ovf_o=1. Then snap_ready_i=1 gives snap_valid_o=0.
- Simultaneous: snap_valid_o=1 with snap_req_i=1, snap_ready_i=1 and a LOAD in the same cycle. snap_o takes the old state, state_o takes the new state, snap_valid_o stays 1, and snap_ovf_o does not change.
- Reset mid-operation: snap_valid_o=1, snap_ovf_o=1, nonzero state, then assert reset_i for 1 cycle. All outputs are 0, and a LOAD on the next cycle works normally.

Source files
------------

// File: rtl/state_register_bank.sv
// Parametrised multi-word cipher state register with masked load/XOR updates
// and a one-entry snapshot buffer exported through a valid/ready handshake.
module state_register_bank #(
    parameter int NB_WORDS = 5,
    parameter int WORD_W   = 64,
    parameter int SEL_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic [1:0]                 mode_i,
    input  logic [NB_WORDS-1:0]        word_mask_i,
    input  logic [SEL_W-1:0]           word_sel_i,
    input  logic [NB_WORDS*WORD_W-1:0] state_i,
    input  logic [WORD_W-1:0]          data_i,
    input  logic                       snap_req_i,
    input  logic                       snap_ready_i,
    output logic [NB_WORDS*WORD_W-1:0] state_o,
    output logic [NB_WORDS*WORD_W-1:0] snap_o,
    output logic                       snap_valid_o,
    output logic                       snap_ovf_o,
    output logic                       upd_o,
    output logic                       sel_err_o
);

    localparam int STATE_W = NB_WORDS * WORD_W;

    localparam logic [1:0] MODE_HOLD      = 2'b00;
    localparam logic [1:0] MODE_LOAD      = 2'b01;
    localparam logic [1:0] MODE_XOR_WORD  = 2'b10;
    localparam logic [1:0] MODE_XOR_STATE = 2'b11;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_snap;
    logic               r_snap_valid;
    logic               r_snap_ovf;
    logic               r_upd;
    logic               r_sel_err;

    logic [STATE_W-1:0] w_next_state;
    logic               w_sel_hit;
    logic               w_sel_err;
    logic               w_snap_accept;
    logic               w_snap_consume;
    logic               w_snap_drop;

    always_comb begin
        w_next_state = r_state;
        w_sel_hit    = 1'b0;
        if (en_i) begin
            case (mode_i)
                MODE_HOLD: begin
                end
                MODE_LOAD: begin
                    for (int k = 0; k < NB_WORDS; k++) begin
                        if (word_mask_i[k]) begin
                            w_next_state[k*WORD_W +: WORD_W] = state_i[k*WORD_W +: WORD_W];
                        end
                    end
                end
                MODE_XOR_WORD: begin
                    // An out-of-range select matches no word, so the state holds.
                    for (int k = 0; k < NB_WORDS; k++) begin
                        if (word_sel_i == SEL_W'(k)) begin
                            w_sel_hit = 1'b1;
                            w_next_state[k*WORD_W +: WORD_W] =
                                r_state[k*WORD_W +: WORD_W] ^ data_i;
                        end
                    end
                end
                MODE_XOR_STATE: begin
                    for (int k = 0; k < NB_WORDS; k++) begin
                        if (word_mask_i[k]) begin
                            w_next_state[k*WORD_W +: WORD_W] =
                                r_state[k*WORD_W +: WORD_W] ^ state_i[k*WORD_W +: WORD_W];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_sel_err      = en_i && (mode_i == MODE_XOR_WORD) && !w_sel_hit;
    assign w_snap_accept  = snap_req_i && (!r_snap_valid || snap_ready_i);
    assign w_snap_consume = snap_ready_i && r_snap_valid;
    assign w_snap_drop    = snap_req_i && r_snap_valid && !snap_ready_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= '0;
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            r_snap_ovf   <= 1'b0;
            r_upd        <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_upd     <= (w_next_state != r_state);
            r_sel_err <= w_sel_err;
            if (w_snap_accept) begin
                r_snap       <= r_state;
                r_snap_valid <= 1'b1;
            end else if (w_snap_consume) begin
                r_snap_valid <= 1'b0;
            end
            if (w_snap_drop) begin
                r_snap_ovf <= 1'b1;
            end
        end
    end

    assign state_o      = r_state;
    assign snap_o       = r_snap;
    assign snap_valid_o = r_snap_valid;
    assign snap_ovf_o   = r_snap_ovf;
    assign upd_o        = r_upd;
    assign sel_err_o    = r_sel_err;

endmodule

// File: tb/tb_state_register_bank.sv
// Directed self-checking bench for state_register_bank (5 x 64-bit).
// Each task drives one scenario and checks against hand-computed values.
module tb_state_register_bank;

    localparam int NB = 5;
    localparam int W  = 64;
    localparam int SW = 3;

    localparam logic [W-1:0] C  = 64'h0123456789ABCDEF;
    localparam logic [W-1:0] F  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [W-1:0] X0 = 64'hFEDCBA9889ABCDEF;
    localparam logic [W-1:0] N1 = 64'hFEDCBA9876543210;
    localparam logic [W-1:0] C1 = 64'h0123456789ABCDEE;
    localparam logic [W-1:0] A  = 64'h5555AAAA5555AAAA;
    localparam logic [W-1:0] Z  = 64'h0;

    logic            clk;
    logic            reset_i;
    logic            en_i;
    logic [1:0]      mode_i;
    logic [NB-1:0]   word_mask_i;
    logic [SW-1:0]   word_sel_i;
    logic [NB*W-1:0] state_i;
    logic [W-1:0]    data_i;
    logic            snap_req_i;
    logic            snap_ready_i;
    logic [NB*W-1:0] state_o;
    logic [NB*W-1:0] snap_o;
    logic            snap_valid_o;
    logic            snap_ovf_o;
    logic            upd_o;
    logic            sel_err_o;

    int total = 0;
    int bad   = 0;

    logic [NB*W-1:0] exp_state;
    logic [NB*W-1:0] exp_snap;

    state_register_bank #(
        .NB_WORDS(NB),
        .WORD_W  (W),
        .SEL_W   (SW)
    ) dut (
        .clock_i     (clk),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .word_mask_i (word_mask_i),
        .word_sel_i  (word_sel_i),
        .state_i     (state_i),
        .data_i      (data_i),
        .snap_req_i  (snap_req_i),
        .snap_ready_i(snap_ready_i),
        .state_o     (state_o),
        .snap_o      (snap_o),
        .snap_valid_o(snap_valid_o),
        .snap_ovf_o  (snap_ovf_o),
        .upd_o       (upd_o),
        .sel_err_o   (sel_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_i         = 1'b0;
        mode_i       = 2'b00;
        word_mask_i  = '0;
        word_sel_i   = '0;
        state_i      = '0;
        data_i       = '0;
        snap_req_i   = 1'b0;
        snap_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        total++;
        if (state_o !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", state_o);
        end
        total++;
        if (snap_valid_o !== 1'b0 || snap_ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_snap got valid=%b ovf=%b want 0 0", snap_valid_o, snap_ovf_o);
        end
        total++;
        if (upd_o !== 1'b0 || sel_err_o !== 1'b0 || snap_o !== '0) begin
            bad++;
            $display("FAIL reset_flags got upd=%b selerr=%b snap=%h want 0", upd_o, sel_err_o, snap_o);
        end
    endtask

    task automatic test_load();
        en_i = 1'b1;
        mode_i = 2'b01;
        word_mask_i = 5'b11111;
        state_i = {C, C, C, C, C};
        step();
        idle();
        exp_state = {C, C, C, C, C};
        total++;
        if (state_o !== exp_state || upd_o !== 1'b1) begin
            bad++;
            $display("FAIL load_full got=%h upd=%b want=%h upd=1", state_o, upd_o, exp_state);
        end
    endtask

    task automatic test_masked_load();
        en_i = 1'b1;
        mode_i = 2'b01;
        word_mask_i = 5'b00100;
        state_i = {F, F, F, F, F};
        step();
        exp_state = {C, C, F, C, C};
        total++;
        if (state_o !== exp_state || upd_o !== 1'b1) begin
            bad++;
            $display("FAIL load_masked got=%h upd=%b want=%h upd=1", state_o, upd_o, exp_state);
        end
        en_i = 1'b0;
        word_mask_i = 5'b11111;
        step();
        total++;
        if (state_o !== exp_state || upd_o !== 1'b0) begin
            bad++;
            $display("FAIL load_disabled got=%h upd=%b want=%h upd=0", state_o, upd_o, exp_state);
        end
        en_i = 1'b1;
        word_mask_i = 5'b00000;
        step();
        idle();
        total++;
        if (state_o !== exp_state || upd_o !== 1'b0) begin
            bad++;
            $display("FAIL load_mask0 got=%h upd=%b want=%h upd=0", state_o, upd_o, exp_state);
        end
    endtask

    task automatic test_xor_word();
        en_i = 1'b1;
        mode_i = 2'b10;
        word_sel_i = 3'd0;
        data_i = 64'hFFFFFFFF00000000;
        step();
        exp_state = {C, C, F, C, X0};
        total++;
        if (state_o !== exp_state || upd_o !== 1'b1 || sel_err_o !== 1'b0) begin
            bad++;
            $display("FAIL xor_word got=%h upd=%b selerr=%b want=%h 1 0", state_o, upd_o, sel_err_o, exp_state);
        end
        word_sel_i = 3'd5;
        step();
        total++;
        if (state_o !== exp_state || upd_o !== 1'b0 || sel_err_o !== 1'b1) begin
            bad++;
            $display("FAIL xor_word_badsel got=%h upd=%b selerr=%b want=%h 0 1", state_o, upd_o, sel_err_o, exp_state);
        end
        word_sel_i = 3'd7;
        en_i = 1'b0;
        step();
        total++;
        if (sel_err_o !== 1'b0) begin
            bad++;
            $display("FAIL selerr_disabled got=%b want=0", sel_err_o);
        end
        en_i = 1'b1;
        word_sel_i = 3'd4;
        data_i = '0;
        step();
        idle();
        total++;
        if (state_o !== exp_state || upd_o !== 1'b0 || sel_err_o !== 1'b0) begin
            bad++;
            $display("FAIL xor_word_zero got=%h upd=%b selerr=%b want=%h 0 0", state_o, upd_o, sel_err_o, exp_state);
        end
    endtask

    task automatic test_xor_state();
        en_i = 1'b1;
        mode_i = 2'b11;
        word_mask_i = 5'b00010;
        state_i = {F, F, F, F, F};
        step();
        idle();
        exp_state = {C, C, F, N1, X0};
        total++;
        if (state_o !== exp_state || upd_o !== 1'b1) begin
            bad++;
            $display("FAIL xor_state got=%h upd=%b want=%h upd=1", state_o, upd_o, exp_state);
        end
    endtask

    task automatic test_simultaneous();
        snap_req_i = 1'b1;
        en_i = 1'b1;
        mode_i = 2'b10;
        word_sel_i = 3'd3;
        data_i = 64'h1;
        step();
        exp_snap = {C, C, F, N1, X0};
        exp_state = {C, C1, F, N1, X0};
        total++;
        if (snap_valid_o !== 1'b1 || snap_o !== exp_snap || state_o !== exp_state) begin
            bad++;
            $display("FAIL sim_first got v=%b snap=%h st=%h want v=1 snap=%h st=%h",
                     snap_valid_o, snap_o, state_o, exp_snap, exp_state);
        end
        snap_ready_i = 1'b1;
        mode_i = 2'b01;
        word_mask_i = 5'b11111;
        state_i = {A, A, A, A, A};
        step();
        idle();
        exp_snap = {C, C1, F, N1, X0};
        exp_state = {A, A, A, A, A};
        total++;
        if (snap_o !== exp_snap || state_o !== exp_state) begin
            bad++;
            $display("FAIL sim_both got snap=%h st=%h want snap=%h st=%h", snap_o, state_o, exp_snap, exp_state);
        end
        total++;
        if (snap_valid_o !== 1'b1 || snap_ovf_o !== 1'b0 || upd_o !== 1'b1) begin
            bad++;
            $display("FAIL sim_flags got v=%b ovf=%b upd=%b want 1 0 1", snap_valid_o, snap_ovf_o, upd_o);
        end
        snap_ready_i = 1'b1;
        step();
        idle();
        total++;
        if (snap_valid_o !== 1'b0 || snap_o !== exp_snap) begin
            bad++;
            $display("FAIL sim_drain got v=%b snap=%h want v=0 snap=%h", snap_valid_o, snap_o, exp_snap);
        end
    endtask

    task automatic test_snapshot();
        snap_req_i = 1'b1;
        en_i = 1'b1;
        mode_i = 2'b01;
        word_mask_i = 5'b10000;
        state_i = '0;
        step();
        idle();
        exp_snap = {A, A, A, A, A};
        exp_state = {Z, A, A, A, A};
        total++;
        if (snap_valid_o !== 1'b1 || snap_o !== exp_snap || state_o !== exp_state) begin
            bad++;
            $display("FAIL snap_take got v=%b snap=%h st=%h want v=1 snap=%h st=%h",
                     snap_valid_o, snap_o, state_o, exp_snap, exp_state);
        end
        snap_req_i = 1'b1;
        step();
        idle();
        total++;
        if (snap_valid_o !== 1'b1 || snap_o !== exp_snap || snap_ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL snap_ovf got v=%b ovf=%b snap=%h want v=1 ovf=1 snap=%h",
                     snap_valid_o, snap_ovf_o, snap_o, exp_snap);
        end
        snap_ready_i = 1'b1;
        step();
        total++;
        if (snap_valid_o !== 1'b0 || snap_o !== exp_snap || snap_ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL snap_consume got v=%b ovf=%b snap=%h want v=0 ovf=1 snap=%h",
                     snap_valid_o, snap_ovf_o, snap_o, exp_snap);
        end
        step();
        idle();
        total++;
        if (snap_valid_o !== 1'b0 || snap_o !== exp_snap) begin
            bad++;
            $display("FAIL snap_idle_ready got v=%b snap=%h want v=0 snap=%h", snap_valid_o, snap_o, exp_snap);
        end
    endtask

    task automatic test_reset_mid();
        snap_req_i = 1'b1;
        step();
        idle();
        total++;
        if (snap_valid_o !== 1'b1 || snap_ovf_o !== 1'b1 || state_o === '0) begin
            bad++;
            $display("FAIL mid_setup got v=%b ovf=%b st=%h want v=1 ovf=1 st!=0", snap_valid_o, snap_ovf_o, state_o);
        end
        reset_i = 1'b1;
        en_i = 1'b1;
        mode_i = 2'b01;
        word_mask_i = 5'b11111;
        state_i = {F, F, F, F, F};
        snap_req_i = 1'b1;
        snap_ready_i = 1'b1;
        step();
        reset_i = 1'b0;
        idle();
        total++;
        if (state_o !== '0 || snap_o !== '0 || snap_valid_o !== 1'b0 ||
            snap_ovf_o !== 1'b0 || upd_o !== 1'b0 || sel_err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got st=%h snap=%h v=%b ovf=%b upd=%b se=%b want all 0",
                     state_o, snap_o, snap_valid_o, snap_ovf_o, upd_o, sel_err_o);
        end
        en_i = 1'b1;
        mode_i = 2'b01;
        word_mask_i = 5'b11111;
        state_i = {C, C, C, C, C};
        step();
        idle();
        exp_state = {C, C, C, C, C};
        total++;
        if (state_o !== exp_state || upd_o !== 1'b1 || snap_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reload got st=%h upd=%b v=%b want st=%h upd=1 v=0",
                     state_o, upd_o, snap_valid_o, exp_state);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        test_reset();
        test_load();
        test_masked_load();
        test_xor_word();
        test_xor_state();
        test_simultaneous();
        test_snapshot();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
